tdm_demux: RTL and testbench
============================

// Module: tdm_demux
// PURPOSE
//   Receive end of the board-side time-division mux: one shared W-bit lane carries N_SLOTS
//   samples per frame, the first one marked by in_sof. Rebuilds a frame in shadow registers
//   and commits it atomically to out_data, so LEDs and 7-seg fields never show a torn frame.
//   Sits between the TDM lane (switch/IO logic) and the display drivers.
// PARAMETERS
//   WIDTH    8  bits per slot sample
//   N_SLOTS  4  slots per frame, >=1; slot 0 is the sof beat
// PORTS
//   clk         in   1              system clock, all logic on posedge
//   rst         in   1              synchronous, active-high reset
//   in_valid    in   1              beat qualifier for in_sof/in_data
//   in_sof      in   1              beat is slot 0 of a frame (ignored when in_valid=0)
//   in_data     in   WIDTH          slot sample
//   out_data    out  N_SLOTS*WIDTH  last committed frame; slot k at [k*WIDTH +: WIDTH]
//   out_valid   out  1              sticky: 1 once any frame has been committed
//   frame_done  out  1              1-cycle pulse: out_data updated this cycle
//   frame_err   out  1              1-cycle pulse: protocol violation seen
// BEHAVIOUR
//   Reset: state=IDLE, slot index=0, shadow=0, out_data=0, out_valid=0, frame_done=0,
//     frame_err=0. Reset mid-frame discards the partial frame; out_data is cleared.
//   All outputs registered. No backpressure: every valid beat is consumed that cycle.
//   IDLE:
//     valid&sof  -> shadow[0]=in_data, idx=1, ->COLLECT (N_SLOTS=1: commit at once, stay IDLE)
//     valid&!sof -> beat dropped, frame_err pulses next cycle, stay IDLE
//     !valid     -> hold
//   COLLECT:
//     valid&!sof -> shadow[idx]=in_data; idx==N_SLOTS-1: commit, idx=0, ->IDLE; else idx++
//     valid&sof  -> short frame: frame_err pulse, partial discarded, beat taken as new
//                   slot 0 (shadow[0]=in_data, idx=1), stay COLLECT
//     !valid     -> hold; gaps of any length are legal, no timeout
//   Commit: out_data=shadow contents including the final beat, frame_done=1, out_valid=1,
//     all in the cycle after the last beat is sampled (latency 1 from last beat).
//   Slots not rewritten since the previous frame are never exposed (every commit writes all).
//   Back-to-back frames (sof the cycle after last beat) are full rate, no bubble.
//   frame_done and frame_err are never both 1 (a commit cannot be a violation).
//   idx width = max(1,$clog2(N_SLOTS)); idx never exceeds N_SLOTS-1.
// STRUCTURE
//   Shared package/header tdm_defs: state encodings (ST_IDLE, ST_COLLECT), default
//     WIDTH/N_SLOTS, shared with the transmit-side tdm mux.
//   One sub-module: tdm_slot_counter (idx register, load-1/inc/clear, last-slot flag).
//   Shadow bank and output register stay in tdm_demux.
// TESTING (WIDTH=8, N_SLOTS=4)
//   Reset then idle 10 cycles -> out_data=0, out_valid=0, no pulses.
//   Beats sof:A1, B2, C3, D4 back-to-back -> next cycle out_data=32'hD4C3B2A1,
//     frame_done 1 cycle, out_valid=1.
//   Same frame with 3-cycle gaps between beats -> identical result, out_data unchanged
//     until the cycle after D4.
//   sof:11, 22, then sof:55, 66, 77, 88 -> frame_err pulse at the second sof, then
//     out_data=32'h88776655; 11/22 never visible.
//   Stray valid&!sof beat 0xEE in IDLE -> frame_err pulse, out_data unchanged.
//   rst asserted after 2 beats of a frame -> out_data=0, out_valid=0; next full frame
//     commits normally.

Source files
------------

// File: rtl/tdm_defs_pkg.sv
// Shared TDM lane definitions: state encodings and defaults used by both the
// transmit-side mux and the receive-side demux.
package tdm_defs;

    localparam logic [0:0] ST_IDLE    = 1'b0;
    localparam logic [0:0] ST_COLLECT = 1'b1;

    localparam int DEF_WIDTH   = 8;
    localparam int DEF_N_SLOTS = 4;

    // Slot index width; a single-slot frame still needs a 1-bit index.
    function automatic int idx_width(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/tdm_demux_slot_counter.sv
// Slot index register for the TDM demux: load-to-1 on sof, increment on
// continuation beats, clear on commit, plus a last-slot flag.
module tdm_slot_counter
    import tdm_defs::*;
#(
    parameter int N_SLOTS = DEF_N_SLOTS,
    parameter int IDX_W   = idx_width(N_SLOTS)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load1,
    input  logic             inc,
    input  logic             clr,
    output logic [IDX_W-1:0] idx,
    output logic             is_last
);

    localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(N_SLOTS - 1);
    localparam logic [IDX_W-1:0] IDX_FIRST = IDX_W'((N_SLOTS > 1) ? 1 : 0);

    logic [IDX_W-1:0] idx_q, idx_d;

    always_comb begin
        idx_d = idx_q;
        if (clr)
            idx_d = '0;
        else if (load1)
            idx_d = IDX_FIRST;
        else if (inc && (idx_q != IDX_LAST))
            idx_d = idx_q + IDX_W'(1);
    end

    always_ff @(posedge clk) begin
        if (rst)
            idx_q <= '0;
        else
            idx_q <= idx_d;
    end

    assign idx     = idx_q;
    assign is_last = (idx_q == IDX_LAST);

endmodule

// File: rtl/tdm_demux.sv
// Receive side of the TDM lane: collects one frame of slots into a shadow bank
// and publishes it to out_data in a single cycle so displays never see a torn frame.
module tdm_demux
    import tdm_defs::*;
#(
    parameter int WIDTH   = DEF_WIDTH,
    parameter int N_SLOTS = DEF_N_SLOTS
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    input  logic                       in_sof,
    input  logic [WIDTH-1:0]           in_data,
    output logic [N_SLOTS*WIDTH-1:0]   out_data,
    output logic                       out_valid,
    output logic                       frame_done,
    output logic                       frame_err
);

    localparam int IDX_W = idx_width(N_SLOTS);

    logic [0:0]                         state_q, state_d;
    logic [N_SLOTS-1:0][WIDTH-1:0]      shadow_q, shadow_d;
    logic [N_SLOTS-1:0][WIDTH-1:0]      out_q, out_d;
    logic                               out_valid_q, out_valid_d;
    logic                               frame_done_q, frame_done_d;
    logic                               frame_err_q, frame_err_d;

    logic [IDX_W-1:0]                   idx;
    logic                               is_last;
    logic                               load1, inc, clr, commit;

    tdm_slot_counter #(
        .N_SLOTS (N_SLOTS),
        .IDX_W   (IDX_W)
    ) u_slot_counter (
        .clk     (clk),
        .rst     (rst),
        .load1   (load1),
        .inc     (inc),
        .clr     (clr),
        .idx     (idx),
        .is_last (is_last)
    );

    always_comb begin
        state_d  = state_q;
        shadow_d = shadow_q;
        load1    = 1'b0;
        inc      = 1'b0;
        clr      = 1'b0;
        commit   = 1'b0;
        frame_err_d = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (in_valid && in_sof) begin
                    shadow_d[0] = in_data;
                    if (N_SLOTS == 1) begin
                        commit = 1'b1;
                    end else begin
                        load1   = 1'b1;
                        state_d = ST_COLLECT;
                    end
                end else if (in_valid) begin
                    frame_err_d = 1'b1;
                end
            end
            ST_COLLECT: begin
                if (in_valid && in_sof) begin
                    // Short frame: restart on this beat, the partial frame is abandoned.
                    frame_err_d = 1'b1;
                    shadow_d[0] = in_data;
                    load1       = 1'b1;
                end else if (in_valid) begin
                    for (int k = 0; k < N_SLOTS; k++)
                        if (idx == IDX_W'(k))
                            shadow_d[k] = in_data;
                    if (is_last) begin
                        commit  = 1'b1;
                        clr     = 1'b1;
                        state_d = ST_IDLE;
                    end else begin
                        inc = 1'b1;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
                clr     = 1'b1;
            end
        endcase

        // Commit takes the shadow bank including the beat sampled this cycle.
        out_d        = commit ? shadow_d : out_q;
        out_valid_d  = out_valid_q | commit;
        frame_done_d = commit;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            shadow_q     <= '0;
            out_q        <= '0;
            out_valid_q  <= 1'b0;
            frame_done_q <= 1'b0;
            frame_err_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            shadow_q     <= shadow_d;
            out_q        <= out_d;
            out_valid_q  <= out_valid_d;
            frame_done_q <= frame_done_d;
            frame_err_q  <= frame_err_d;
        end
    end

    assign out_data   = out_q;
    assign out_valid  = out_valid_q;
    assign frame_done = frame_done_q;
    assign frame_err  = frame_err_q;

endmodule

// File: tb/tb_tdm_demux.sv
// Bench for tdm_demux: directed frames plus random beats against a queue-based
// frame model, with every cycle's registered outputs compared.
module tb_tdm_demux;

    localparam int W = 8;
    localparam int N = 4;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic           in_valid = 1'b0;
    logic           in_sof = 1'b0;
    logic [W-1:0]   in_data = '0;
    logic [N*W-1:0] out_data;
    logic           out_valid, frame_done, frame_err;

    tdm_demux #(.WIDTH(W), .N_SLOTS(N)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_sof     (in_sof),
        .in_data    (in_data),
        .out_data   (out_data),
        .out_valid  (out_valid),
        .frame_done (frame_done),
        .frame_err  (frame_err)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Model: beats of the frame in progress, plus the visible output state.
    logic [W-1:0]   part_q[$];
    logic [N*W-1:0] m_out    = '0;
    logic           m_ovalid = 1'b0;
    logic           m_done   = 1'b0;
    logic           m_err    = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model(input logic r, input logic v, input logic s, input logic [W-1:0] d);
        m_done = 1'b0;
        m_err  = 1'b0;
        if (r) begin
            part_q.delete();
            m_out    = '0;
            m_ovalid = 1'b0;
        end else if (v) begin
            if (s) begin
                if (part_q.size() > 0) m_err = 1'b1;
                part_q.delete();
                part_q.push_back(d);
            end else if (part_q.size() == 0) begin
                m_err = 1'b1;
            end else begin
                part_q.push_back(d);
            end
            if (part_q.size() == N) begin
                for (int k = 0; k < N; k++) m_out[k*W +: W] = part_q[k];
                m_ovalid = 1'b1;
                m_done   = 1'b1;
                part_q.delete();
            end
        end
    endtask

    // One clock: apply inputs, advance the model, then compare after the edge.
    task automatic step(input logic r, input logic v, input logic s, input logic [W-1:0] d);
        rst = r; in_valid = v; in_sof = s; in_data = d;
        model(r, v, s, d);
        @(posedge clk);
        #1;
        chk("out_data",   out_data,   m_out);
        chk("out_valid",  out_valid,  m_ovalid);
        chk("frame_done", frame_done, m_done);
        chk("frame_err",  frame_err,  m_err);
        chk("done_err_excl", frame_done & frame_err, 1'b0);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, ($urandom_range(0, 1) == 1), W'($urandom));
    endtask

    task automatic send(input logic [N*W-1:0] beats, input int gap);
        for (int k = 0; k < N; k++) begin
            step(1'b0, 1'b1, (k == 0), beats[k*W +: W]);
            if (k != N - 1) idle(gap);
        end
    endtask

    initial begin
        step(1'b1, 1'b0, 1'b0, '0);
        step(1'b1, 1'b0, 1'b0, '0);
        idle(10);
        chk("reset_out",    out_data,  32'h0);
        chk("reset_ovalid", out_valid, 1'b0);

        send(32'hD4C3B2A1, 0);
        chk("b2b_done",  frame_done, 1'b1);
        chk("b2b_out",   out_data,   32'hD4C3B2A1);
        chk("mdl_b2b",   m_out,      32'hD4C3B2A1);
        chk("b2b_valid", out_valid,  1'b1);
        idle(1);
        chk("done_pulse_width", frame_done, 1'b0);

        step(1'b0, 1'b1, 1'b1, 8'h11);
        step(1'b0, 1'b1, 1'b0, 8'h22);
        step(1'b0, 1'b1, 1'b1, 8'h55);
        chk("short_err", frame_err, 1'b1);
        chk("mdl_short_err", m_err, 1'b1);
        step(1'b0, 1'b1, 1'b0, 8'h66);
        chk("short_err_pulse", frame_err, 1'b0);
        step(1'b0, 1'b1, 1'b0, 8'h77);
        step(1'b0, 1'b1, 1'b0, 8'h88);
        chk("short_out", out_data, 32'h88776655);
        chk("mdl_short", m_out,    32'h88776655);
        idle(2);

        step(1'b0, 1'b1, 1'b1, 8'hA1);
        idle(3);
        step(1'b0, 1'b1, 1'b0, 8'hB2);
        idle(3);
        step(1'b0, 1'b1, 1'b0, 8'hC3);
        idle(3);
        chk("gap_hold", out_data, 32'h88776655);
        step(1'b0, 1'b1, 1'b0, 8'hD4);
        chk("gap_out",  out_data,   32'hD4C3B2A1);
        chk("gap_done", frame_done, 1'b1);
        idle(2);

        step(1'b0, 1'b1, 1'b0, 8'hEE);
        chk("stray_err", frame_err, 1'b1);
        chk("stray_out", out_data,  32'hD4C3B2A1);
        idle(2);

        step(1'b0, 1'b1, 1'b1, 8'h31);
        step(1'b0, 1'b1, 1'b0, 8'h32);
        step(1'b1, 1'b0, 1'b0, 8'h00);
        chk("rst_mid_out",    out_data,  32'h0);
        chk("rst_mid_ovalid", out_valid, 1'b0);
        send(32'h04030201, 1);
        chk("post_rst_out", out_data, 32'h04030201);
        chk("mdl_post_rst", m_out,    32'h04030201);
        idle(2);

        for (int i = 0; i < 600; i++) begin
            step(($urandom_range(0, 99) < 2),
                 ($urandom_range(0, 99) < 70),
                 ($urandom_range(0, 99) < 22),
                 W'($urandom));
        end
        idle(3);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
